// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF subframe transmitter: frame geometry,
// preamble patterns (for a previous line level of 0), slot positions and channel tag.
package spdif_pkg;

  localparam int CELLS_PER_FRAME  = 128;
  localparam int FRAMES_PER_BLOCK = 192;

  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  localparam logic [4:0] SLOT_AUDIO = 5'd4;
  localparam logic [4:0] SLOT_V     = 5'd28;
  localparam logic [4:0] SLOT_U     = 5'd29;
  localparam logic [4:0] SLOT_C     = 5'd30;
  localparam logic [4:0] SLOT_P     = 5'd31;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_e;

  typedef enum logic [1:0] {
    PSEL_NONE,
    PSEL_B,
    PSEL_M,
    PSEL_W
  } pre_sel_e;

  function automatic logic [7:0] pre_pattern(input pre_sel_e sel);
    case (sel)
      PSEL_B:  return PRE_B;
      PSEL_M:  return PRE_M;
      PSEL_W:  return PRE_W;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spdif_bmc_enc.sv
// Biphase-mark line encoder: owns the line-level register and emits one half-cell
// per clock, either a preamble cell (level-relative) or a BMC-coded data cell.
module spdif_bmc_enc
  import spdif_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_bit,
  input  logic       i_second,
  input  pre_sel_e   i_pre_sel,
  input  logic [2:0] i_pre_cell,
  output logic       o_line
);

  logic       r_level;
  logic       r_pre_inv;
  logic       w_inv;
  logic       w_next;
  logic [7:0] w_pat;

  // Preamble polarity is latched from the line level preceding its first cell.
  always_comb begin
    w_pat  = pre_pattern(i_pre_sel);
    w_inv  = (i_pre_cell == 3'd0) ? r_level : r_pre_inv;
    w_next = r_level;
    if (i_pre_sel != PSEL_NONE) begin
      w_next = w_pat[3'd7 - i_pre_cell] ^ w_inv;
    end else if (!i_second) begin
      w_next = ~r_level;
    end else begin
      w_next = r_level ^ i_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level   <= 1'b0;
      r_pre_inv <= 1'b0;
    end else begin
      r_level <= w_next;
      if (i_pre_sel != PSEL_NONE && i_pre_cell == 3'd0) begin
        r_pre_inv <= r_level;
      end
    end
  end

  assign o_line = r_level;

endmodule

// File: rtl/spdif_subframe_tx.sv
// S/PDIF subframe transmitter: one-word holding register, 32-slot subframe formatting
// and BMC line output. Define SPDIF_CHSTAT_EN to send CHSTAT_BITS in the C slot.
module spdif_subframe_tx
  import spdif_pkg::*;
#(
  parameter int           DATA_WIDTH  = 32,
  parameter logic [191:0] CHSTAT_BITS = 192'h0200_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_stb,
  output logic                  ready,
  output logic                  spdif_out,
  output logic                  block_start,
  output logic                  underflow,
  output logic                  overrun
);

  logic [6:0]  r_cell_cnt;
  logic [7:0]  r_frame_cnt;
  logic        r_full;
  logic [26:0] r_hold;
  logic [23:0] r_sf_audio;
  logic        r_sf_v;
  logic        r_sf_u;
  logic        r_sf_p;
  logic        r_block_start;

  logic        w_load;
  logic        w_consume;
  logic        w_capture;
  logic        w_c;
  logic        w_bit;
  logic        w_second;
  logic [4:0]  w_slot;
  logic [2:0]  w_pre_cell;
  pre_sel_e    w_pre_sel;
  chan_e       w_chan;
  chan_e       w_tag;
  logic [23:0] w_ld_audio;
  logic        w_ld_v;
  logic        w_ld_u;

  function automatic logic even_parity(input logic [26:0] slots);
    return ^slots;
  endfunction

`ifdef SPDIF_CHSTAT_EN
  assign w_c = CHSTAT_BITS[r_frame_cnt];
`else
  logic w_unused_chstat;
  assign w_unused_chstat = ^CHSTAT_BITS;
  assign w_c = 1'b0;
`endif

  generate
    if (DATA_WIDTH > 27) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^data_in[DATA_WIDTH-1:27];
    end
  endgenerate

  assign w_chan    = chan_e'(r_cell_cnt[6]);
  assign w_tag     = chan_e'(r_hold[26]);
  assign w_load    = !reset && (r_cell_cnt[5:0] == 6'd0);
  assign w_consume = w_load && r_full && (w_tag == w_chan);
  // A word strobed in the consume cycle refills the register behind the departing one.
  assign w_capture = !reset && data_stb && (!r_full || w_consume);

  assign ready     = !r_full;
  assign underflow = w_load && !w_consume;
  assign overrun   = !reset && data_stb && r_full && !w_consume;

  always_comb begin
    w_ld_audio = 24'd0;
    w_ld_v     = 1'b1;
    w_ld_u     = 1'b0;
    if (w_consume) begin
      w_ld_audio = r_hold[23:0];
      w_ld_v     = r_hold[24];
      w_ld_u     = r_hold[25];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cell_cnt    <= 7'd0;
      r_frame_cnt   <= 8'd0;
      r_full        <= 1'b0;
      r_block_start <= 1'b0;
    end else begin
      r_cell_cnt    <= (r_cell_cnt == 7'(CELLS_PER_FRAME - 1)) ? 7'd0 : r_cell_cnt + 7'd1;
      if (r_cell_cnt == 7'(CELLS_PER_FRAME - 1)) begin
        r_frame_cnt <= (r_frame_cnt == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : r_frame_cnt + 8'd1;
      end
      r_block_start <= (r_cell_cnt == 7'd0) && (r_frame_cnt == 8'd0);
      if (w_capture) begin
        r_full <= 1'b1;
      end else if (w_consume) begin
        r_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_hold <= data_in[26:0];
    end
    if (w_load) begin
      r_sf_audio <= w_ld_audio;
      r_sf_v     <= w_ld_v;
      r_sf_u     <= w_ld_u;
      r_sf_p     <= even_parity({w_c, w_ld_u, w_ld_v, w_ld_audio});
    end
  end

  assign w_slot     = r_cell_cnt[5:1];
  assign w_second   = r_cell_cnt[0];
  assign w_pre_cell = r_cell_cnt[2:0];

  always_comb begin
    w_pre_sel = PSEL_NONE;
    w_bit     = 1'b0;
    if (w_slot < SLOT_AUDIO) begin
      if (w_chan == CH_B) begin
        w_pre_sel = PSEL_W;
      end else if (r_frame_cnt == 8'd0) begin
        w_pre_sel = PSEL_B;
      end else begin
        w_pre_sel = PSEL_M;
      end
    end else if (w_slot < SLOT_V) begin
      w_bit = r_sf_audio[w_slot - SLOT_AUDIO];
    end else begin
      case (w_slot)
        SLOT_V:  w_bit = r_sf_v;
        SLOT_U:  w_bit = r_sf_u;
        SLOT_C:  w_bit = w_c;
        SLOT_P:  w_bit = r_sf_p;
        default: w_bit = 1'b0;
      endcase
    end
  end

  spdif_bmc_enc u_bmc (
    .clk        (clk),
    .reset      (reset),
    .i_bit      (w_bit),
    .i_second   (w_second),
    .i_pre_sel  (w_pre_sel),
    .i_pre_cell (w_pre_cell),
    .o_line     (spdif_out)
  );

  assign block_start = r_block_start;

endmodule

// File: tb/tb_spdif_subframe_tx.sv
// Directed bench for spdif_subframe_tx: records one frame of line cells and pulses,
// then decodes preambles and biphase-mark slots and compares them with hand values.
module tb_spdif_subframe_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_stb = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        ready, spdif_out, block_start, underflow, overrun;

  spdif_subframe_tx #(.DATA_WIDTH(32), .CHSTAT_BITS(192'h0200_0000)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_stb(data_stb), .ready(ready),
    .spdif_out(spdif_out), .block_start(block_start), .underflow(underflow), .overrun(overrun)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] EXP_B = 8'b1110_1000;
  localparam logic [7:0] EXP_M = 8'b1110_0010;
  localparam logic [7:0] EXP_W = 8'b1110_0100;

  int n_vec = 0;
  int n_err = 0;
  int tb_cell = 0;
  int tb_frame = 0;
  logic pre_lvl_run = 1'b0;
  logic pre_lvl_done = 1'b0;
  logic line_hist [0:127];
  logic uf_at [0:127];
  logic ov_at [0:127];
  logic rdy_at [0:127];
  logic bs_at [0:127];
  int stb_at [0:3] = '{-1, -1, -1, -1};
  logic [31:0] stb_w [0:3];

  logic [7:0]  d_pre;
  logic [23:0] d_audio;
  logic d_v, d_u, d_c, d_p, d_ok;

  task automatic tick();
    #1;
    uf_at[tb_cell] = underflow;
    ov_at[tb_cell] = overrun;
    @(posedge clk); #1;
    data_stb = 1'b0;
    line_hist[tb_cell] = spdif_out;
    bs_at[tb_cell] = block_start;
    rdy_at[tb_cell] = ready;
    if (tb_cell == 127) begin
      tb_cell = 0;
      tb_frame = (tb_frame == 191) ? 0 : tb_frame + 1;
      pre_lvl_done = pre_lvl_run;
      pre_lvl_run = line_hist[127];
    end else begin
      tb_cell++;
    end
  endtask

  task automatic run_frame();
    for (int c = 0; c < 128; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (stb_at[k] == c) begin
          data_stb = 1'b1;
          data_in = stb_w[k];
        end
      end
      tick();
    end
  endtask

  task automatic decode_sub(input int base, input logic prev);
    logic lvl, c1, c2, b;
    for (int k = 0; k < 8; k++) d_pre[7-k] = line_hist[base+k] ^ prev;
    lvl = line_hist[base+7];
    d_ok = 1'b1;
    for (int s = 4; s < 32; s++) begin
      c1 = line_hist[base+2*s];
      c2 = line_hist[base+2*s+1];
      if (c1 === lvl) d_ok = 1'b0;
      b = c1 ^ c2;
      if (s < 28) d_audio[s-4] = b;
      else if (s == 28) d_v = b;
      else if (s == 29) d_u = b;
      else if (s == 30) d_c = b;
      else d_p = b;
      lvl = c2;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_stb = 1'b1;
    data_in = 32'h0000_0001;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (spdif_out !== 1'b0) begin n_err++; $display("FAIL rst_line: got %b want 0", spdif_out); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_vec++; if (block_start !== 1'b0) begin n_err++; $display("FAIL rst_bs: got %b want 0", block_start); end
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_uf: got %b want 0", underflow); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_ov: got %b want 0", overrun); end
    data_stb = 1'b0;
    reset = 1'b0;
    tb_cell = 0; tb_frame = 0; pre_lvl_run = 1'b0; pre_lvl_done = 1'b0;
  endtask

  task automatic test_underflow_frame();
    logic [7:0] raw;
    stb_at = '{120, -1, -1, -1};
    stb_w[0] = 32'h0000_0001;
    run_frame();
    for (int k = 0; k < 8; k++) raw[7-k] = line_hist[k];
    n_vec++; if (raw !== EXP_B) begin n_err++; $display("FAIL f0_raw_pre: got %b want %b", raw, EXP_B); end
    n_vec++; if (uf_at[0] !== 1'b1) begin n_err++; $display("FAIL f0_uf0: got %b want 1", uf_at[0]); end
    n_vec++; if (uf_at[64] !== 1'b1) begin n_err++; $display("FAIL f0_uf64: got %b want 1", uf_at[64]); end
    n_vec++; if (uf_at[1] !== 1'b0) begin n_err++; $display("FAIL f0_uf1: got %b want 0", uf_at[1]); end
    n_vec++; if (bs_at[0] !== 1'b1) begin n_err++; $display("FAIL f0_bs0: got %b want 1", bs_at[0]); end
    n_vec++; if (bs_at[1] !== 1'b0) begin n_err++; $display("FAIL f0_bs1: got %b want 0", bs_at[1]); end
    n_vec++; if (rdy_at[119] !== 1'b1) begin n_err++; $display("FAIL f0_rdy119: got %b want 1", rdy_at[119]); end
    n_vec++; if (rdy_at[120] !== 1'b0) begin n_err++; $display("FAIL f0_rdy120: got %b want 0", rdy_at[120]); end
    decode_sub(0, pre_lvl_done);
    n_vec++; if (d_pre !== EXP_B) begin n_err++; $display("FAIL f0_a_pre: got %b want %b", d_pre, EXP_B); end
    n_vec++; if ({d_audio, d_v, d_u, d_c, d_p, d_ok} !== {24'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1})
      begin n_err++; $display("FAIL f0_a_fields: got %h/%b%b%b%b%b want 000000/10011", d_audio, d_v, d_u, d_c, d_p, d_ok); end
    decode_sub(64, line_hist[63]);
    n_vec++; if (d_pre !== EXP_W) begin n_err++; $display("FAIL f0_b_pre: got %b want %b", d_pre, EXP_W); end
    n_vec++; if ({d_audio, d_v, d_p, d_ok} !== {24'h0, 1'b1, 1'b1, 1'b1})
      begin n_err++; $display("FAIL f0_b_fields: got %h/%b%b%b want 000000/111", d_audio, d_v, d_p, d_ok); end
  endtask

  task automatic test_handshake();
    stb_at = '{1, 10, 64, -1};
    stb_w[0] = 32'h0412_3456;
    stb_w[1] = 32'h00FF_FFFF;
    stb_w[2] = 32'h0680_0000;
    run_frame();
    n_vec++; if (uf_at[0] !== 1'b0) begin n_err++; $display("FAIL f1_uf0: got %b want 0", uf_at[0]); end
    n_vec++; if (rdy_at[0] !== 1'b1) begin n_err++; $display("FAIL f1_rdy0: got %b want 1", rdy_at[0]); end
    n_vec++; if (ov_at[1] !== 1'b0) begin n_err++; $display("FAIL f1_ov1: got %b want 0", ov_at[1]); end
    n_vec++; if (ov_at[10] !== 1'b1) begin n_err++; $display("FAIL f1_ov10: got %b want 1", ov_at[10]); end
    n_vec++; if (ov_at[64] !== 1'b0) begin n_err++; $display("FAIL f1_ov64: got %b want 0", ov_at[64]); end
    n_vec++; if (uf_at[64] !== 1'b0) begin n_err++; $display("FAIL f1_uf64: got %b want 0", uf_at[64]); end
    n_vec++; if (rdy_at[64] !== 1'b0) begin n_err++; $display("FAIL f1_rdy64: got %b want 0", rdy_at[64]); end
    decode_sub(0, pre_lvl_done);
    n_vec++; if (d_pre !== EXP_M) begin n_err++; $display("FAIL f1_a_pre: got %b want %b", d_pre, EXP_M); end
    n_vec++; if ({d_audio, d_v, d_u, d_c, d_p, d_ok} !== {24'h000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1})
      begin n_err++; $display("FAIL f1_a_fields: got %h/%b%b%b%b%b want 000001/00011", d_audio, d_v, d_u, d_c, d_p, d_ok); end
    decode_sub(64, line_hist[63]);
    n_vec++; if (d_pre !== EXP_W) begin n_err++; $display("FAIL f1_b_pre: got %b want %b", d_pre, EXP_W); end
    n_vec++; if ({d_audio, d_v, d_u, d_p, d_ok} !== {24'h123456, 1'b0, 1'b0, 1'b1, 1'b1})
      begin n_err++; $display("FAIL f1_b_fields: got %h/%b%b%b%b want 123456/0011", d_audio, d_v, d_u, d_p, d_ok); end
  endtask

  task automatic test_tag_mismatch();
    int hi;
    stb_at = '{-1, -1, -1, -1};
    run_frame();
    hi = 0;
    for (int c = 0; c < 64; c++) if (rdy_at[c] !== 1'b0) hi++;
    n_vec++; if (uf_at[0] !== 1'b1) begin n_err++; $display("FAIL f2_uf0: got %b want 1", uf_at[0]); end
    n_vec++; if (hi !== 0) begin n_err++; $display("FAIL f2_rdy_low: got %0d high cells want 0", hi); end
    n_vec++; if (rdy_at[64] !== 1'b1) begin n_err++; $display("FAIL f2_rdy64: got %b want 1", rdy_at[64]); end
    n_vec++; if (uf_at[64] !== 1'b0) begin n_err++; $display("FAIL f2_uf64: got %b want 0", uf_at[64]); end
    decode_sub(0, pre_lvl_done);
    n_vec++; if ({d_pre, d_audio, d_v, d_p} !== {EXP_M, 24'h0, 1'b1, 1'b1})
      begin n_err++; $display("FAIL f2_a_fields: got %b/%h/%b%b want %b/000000/11", d_pre, d_audio, d_v, d_p, EXP_M); end
    decode_sub(64, line_hist[63]);
    n_vec++; if (d_pre !== EXP_W) begin n_err++; $display("FAIL f2_b_pre: got %b want %b", d_pre, EXP_W); end
    n_vec++; if ({d_audio, d_v, d_u, d_c, d_p, d_ok} !== {24'h800000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1})
      begin n_err++; $display("FAIL f2_b_fields: got %h/%b%b%b%b%b want 800000/01001", d_audio, d_v, d_u, d_c, d_p, d_ok); end
  endtask

  task automatic test_chstat_block();
    int fr, n_pre_b, n_bs;
    logic exp_c;
    logic [7:0] exp_pre;
    n_pre_b = 0;
    n_bs = 0;
    stb_at = '{-1, -1, -1, -1};
    for (int f = 0; f < 190; f++) begin
      fr = tb_frame;
`ifdef SPDIF_CHSTAT_EN
      exp_c = (fr == 25);
`else
      exp_c = 1'b0;
`endif
      exp_pre = (fr == 0) ? EXP_B : EXP_M;
      run_frame();
      for (int c = 0; c < 128; c++) if (bs_at[c] === 1'b1) n_bs++;
      decode_sub(0, pre_lvl_done);
      if (d_pre === EXP_B) n_pre_b++;
      n_vec++; if ({d_pre, d_c, d_p, d_ok} !== {exp_pre, exp_c, ~exp_c, 1'b1})
        begin n_err++; $display("FAIL cs_a_f%0d: got %b/%b%b%b want %b/%b%b1", fr, d_pre, d_c, d_p, d_ok, exp_pre, exp_c, ~exp_c); end
      decode_sub(64, line_hist[63]);
      n_vec++; if ({d_pre, d_c, d_p, d_ok} !== {EXP_W, exp_c, ~exp_c, 1'b1})
        begin n_err++; $display("FAIL cs_b_f%0d: got %b/%b%b%b want %b/%b%b1", fr, d_pre, d_c, d_p, d_ok, EXP_W, exp_c, ~exp_c); end
    end
    n_vec++; if (n_pre_b !== 1) begin n_err++; $display("FAIL cs_pre_b_count: got %0d want 1", n_pre_b); end
    n_vec++; if (n_bs !== 1) begin n_err++; $display("FAIL cs_bs_count: got %0d want 1", n_bs); end
  endtask

  task automatic test_reset_mid_b();
    int n;
    logic [7:0] raw;
    stb_at = '{-1, -1, -1, -1};
    while (tb_cell < 70) tick();
    n = 0;
    while (spdif_out !== 1'b1 && n < 16) begin tick(); n++; end
    n_vec++; if (spdif_out !== 1'b1) begin n_err++; $display("FAIL midb_high: got %b want 1", spdif_out); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (spdif_out !== 1'b0) begin n_err++; $display("FAIL midb_line: got %b want 0", spdif_out); end
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL midb_uf: got %b want 0", underflow); end
    @(posedge clk); #1;
    reset = 1'b0;
    tb_cell = 0; tb_frame = 0; pre_lvl_run = 1'b0;
    run_frame();
    for (int k = 0; k < 8; k++) raw[7-k] = line_hist[k];
    n_vec++; if (raw !== EXP_B) begin n_err++; $display("FAIL midb_pre: got %b want %b", raw, EXP_B); end
    n_vec++; if (bs_at[0] !== 1'b1) begin n_err++; $display("FAIL midb_bs: got %b want 1", bs_at[0]); end
    n_vec++; if (uf_at[0] !== 1'b1) begin n_err++; $display("FAIL midb_uf0: got %b want 1", uf_at[0]); end
  endtask

  initial begin
    test_reset();
    test_underflow_frame();
    test_handshake();
    test_tag_mismatch();
    test_chstat_block();
    test_reset_mid_b();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
